// File: rtl/exec_wbsel_pkg.sv
// Shared definitions for the execute-stage write-back selector:
// FSM states, result-source select codes and the multiply op code.
package exec_wbsel_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_FULL    = 2'd1,
    ST_DIVWAIT = 2'd2
  } state_e;

  localparam logic [2:0] SEL_ALU = 3'd0;
  localparam logic [2:0] SEL_ADJ = 3'd1;
  localparam logic [2:0] SEL_SHF = 3'd2;
  localparam logic [2:0] SEL_MUL = 3'd3;
  localparam logic [2:0] SEL_DIV = 3'd4;
  localparam logic [2:0] SEL_IN  = 3'd5;
  localparam logic [2:0] SEL_EA  = 3'd6;
  localparam logic [2:0] SEL_CBW = 3'd7;

  localparam logic [2:0] MULOP_CODE = 3'd4;

endpackage

// File: rtl/exec_wbsel_flags.sv
// Combinational result flags: zero/sign per byte or word width, even parity
// of the low byte, and the multiply overflow flag.
module exec_wbsel_flags #(
  parameter int unsigned W = 16
) (
  input  logic [W-1:0] res_i,
  input  logic         bw_i,
  input  logic         sgn_i,
  input  logic         mul_i,
  input  logic [W-1:0] mul_lo_i,
  input  logic [W-1:0] mul_hi_i,
  output logic         zero_o,
  output logic         sign_o,
  output logic         parity_o,
  output logic         mulf_o
);

  logic byte_ovf;
  logic word_ovf;
  logic unused_lo;

  assign zero_o   = bw_i ? (res_i == '0) : (res_i[7:0] == 8'h00);
  assign sign_o   = bw_i ? res_i[W-1] : res_i[7];
  assign parity_o = ~^res_i[7:0];

  // Overflow means the product does not fit back into the destination width.
  assign byte_ovf = sgn_i ? (mul_lo_i[15:8] != {8{mul_lo_i[7]}})
                          : (mul_lo_i[15:8] != 8'h00);
  assign word_ovf = sgn_i ? (mul_hi_i != {W{mul_lo_i[W-1]}})
                          : (mul_hi_i != '0);

  assign mulf_o    = mul_i & (bw_i ? word_ovf : byte_ovf);
  assign unused_lo = ^mul_lo_i;

endmodule

// File: rtl/exec_wbsel.sv
// Execute-stage write-back selector: picks one result source per op, registers
// it with its flags, and parks divide ops until the divider reports done.
module exec_wbsel
  import exec_wbsel_pkg::*;
#(
  parameter int unsigned W      = 16,
  parameter logic [2:0]  MULOP  = MULOP_CODE,
  parameter logic [2:0]  DIVSEL = SEL_DIV
) (
  input  logic         iClk,
  input  logic         iReset,
  input  logic         iValid,
  output logic         oReady,
  input  logic [2:0]   iExec,
  input  logic [3:0]   iFunc,
  input  logic         iBW,
  input  logic         iSgn,
  input  logic [2:0]   iSel,
  input  logic [W-1:0] iAlu,
  input  logic [W-1:0] iAdj,
  input  logic [W-1:0] iShf,
  input  logic [W-1:0] iMulLo,
  input  logic [W-1:0] iMulHi,
  input  logic [W-1:0] iIn,
  input  logic [W-1:0] iEA,
  input  logic [W-1:0] iCbw,
  input  logic [W-1:0] iDiv,
  input  logic         iDivDone,
  output logic         oValid,
  input  logic         iReady,
  output logic [W-1:0] oRes,
  output logic         oZero,
  output logic         oSign,
  output logic         oParity,
  output logic         oMulF
);

  state_e       state_q, state_d;
  logic [W-1:0] res_q, res_d;
  logic [W-1:0] hold_q, hold_d;
  logic         zero_q, zero_d, sign_q, sign_d, par_q, par_d, mulf_q, mulf_d;
  logic         bw_q, bw_d;

  logic [W-1:0] cand_res;
  logic         accept, is_div, div_done, load, flag_bw;
  logic         f_zero, f_sign, f_par, f_mulf;
  logic         unused_func;

  assign oReady   = ~iReset & ((state_q == ST_EMPTY) | ((state_q == ST_FULL) & iReady));
  assign oValid   = (state_q == ST_FULL);
  assign accept   = iValid & oReady;
  assign is_div   = (iSel == DIVSEL);
  assign div_done = (state_q == ST_DIVWAIT) & iDivDone;
  assign load     = (accept & ~is_div) | div_done;
  // A finishing divide uses the width captured when the divide was accepted.
  assign flag_bw  = div_done ? bw_q : iBW;

  always_comb begin
    cand_res = '0;
    if (div_done) begin
      cand_res = iDiv;
    end else begin
      case (iSel)
        SEL_ALU: cand_res = iAlu;
        SEL_ADJ: cand_res = iAdj;
        SEL_SHF: cand_res = iShf;
        SEL_MUL: cand_res = iFunc[0] ? hold_q : iMulLo;
        SEL_IN:  cand_res = iIn;
        SEL_EA:  cand_res = iEA;
        SEL_CBW: cand_res = iCbw;
        default: cand_res = '0;
      endcase
    end
  end

  exec_wbsel_flags #(.W(W)) u_flags (
    .res_i    (cand_res),
    .bw_i     (flag_bw),
    .sgn_i    (iSgn),
    .mul_i    (accept & (iExec == MULOP)),
    .mul_lo_i (iMulLo),
    .mul_hi_i (iMulHi),
    .zero_o   (f_zero),
    .sign_o   (f_sign),
    .parity_o (f_par),
    .mulf_o   (f_mulf)
  );

  always_comb begin
    state_d = state_q;
    res_d   = res_q;
    zero_d  = zero_q;
    sign_d  = sign_q;
    par_d   = par_q;
    mulf_d  = mulf_q;
    hold_d  = hold_q;
    bw_d    = bw_q;

    case (state_q)
      ST_EMPTY:   if (accept) state_d = is_div ? ST_DIVWAIT : ST_FULL;
      ST_FULL:    if (iReady) state_d = accept ? (is_div ? ST_DIVWAIT : ST_FULL) : ST_EMPTY;
      ST_DIVWAIT: if (iDivDone) state_d = ST_FULL;
      default:    state_d = ST_EMPTY;
    endcase

    if (load) begin
      res_d  = cand_res;
      zero_d = f_zero;
      sign_d = f_sign;
      par_d  = f_par;
      mulf_d = f_mulf;
    end
    if (accept) bw_d = iBW;
    if (accept && (iExec == MULOP) && !iFunc[0]) hold_d = iMulHi;
  end

  always_ff @(posedge iClk) begin
    if (iReset) begin
      state_q <= ST_EMPTY;
      res_q   <= '0;
      zero_q  <= 1'b0;
      sign_q  <= 1'b0;
      par_q   <= 1'b0;
      mulf_q  <= 1'b0;
      hold_q  <= '0;
      bw_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
      sign_q  <= sign_d;
      par_q   <= par_d;
      mulf_q  <= mulf_d;
      hold_q  <= hold_d;
      bw_q    <= bw_d;
    end
  end

  assign oRes        = res_q;
  assign oZero       = zero_q;
  assign oSign       = sign_q;
  assign oParity     = par_q;
  assign oMulF       = mulf_q;
  assign unused_func = ^iFunc[3:1];

endmodule
